// File: rtl/dt_enemy_freeze.sv
`default_nettype none
// ============================================================================
//  Module      : dt_enemy_freeze
//  Description : Multi-enemy stomp detector. Tests the player's foot point
//                against N_ENEMY enemy top edges each cycle. A stomp freezes
//                the game for FREEZE_TICKS tick pulses, followed by an
//                immunity window of IMMUNE_TICKS tick pulses.
//                Optional feature macro: FREEZE_RETRIGGER_EN (hits while
//                FROZEN reload the freeze timer).
//  Revision    : 1.0 - initial release
// ============================================================================
module dt_enemy_freeze #(
    parameter int N_ENEMY      = 4,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int FOOT_DX      = 24,
    parameter int FOOT_DY      = 41,
    parameter int ENEMY_W      = 62,
    parameter int TOL_Y        = 2,
    parameter int FREEZE_TICKS = 300,
    parameter int IMMUNE_TICKS = 60
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  tick,
    input  logic [X_W-1:0]                        x_blue,
    input  logic [Y_W-1:0]                        y_blue,
    input  logic [N_ENEMY*X_W-1:0]                x_enemy,
    input  logic [N_ENEMY*Y_W-1:0]                y_enemy,
    input  logic [N_ENEMY-1:0]                    enemy_vld,
    output logic                                  frozen,
    output logic                                  immune,
    output logic                                  freeze_pulse,
    output logic [$clog2(N_ENEMY)-1:0]            hit_id,
    output logic [$clog2(FREEZE_TICKS+1)-1:0]     ticks_left
);

    localparam int ID_W = $clog2(N_ENEMY);
    localparam int TL_W = $clog2(FREEZE_TICKS + 1);

    // All geometry sums carry one extra bit so nothing wraps.
    localparam logic [X_W:0]  C_FOOT_DX  = (X_W+1)'(FOOT_DX);
    localparam logic [Y_W:0]  C_FOOT_DY  = (Y_W+1)'(FOOT_DY);
    localparam logic [X_W:0]  C_ENEMY_W  = (X_W+1)'(ENEMY_W);
    localparam logic [Y_W:0]  C_TOL_Y    = (Y_W+1)'(TOL_Y);
    localparam logic [TL_W-1:0] C_FREEZE = TL_W'(FREEZE_TICKS);
    localparam logic [TL_W-1:0] C_IMMUNE = TL_W'(IMMUNE_TICKS);
    localparam logic [TL_W-1:0] C_ONE    = TL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FROZEN = 2'd1,
        S_IMMUNE = 2'd2
    } state_t;

    state_t             state_q;
    logic [N_ENEMY-1:0] hit_vec_q;
    logic               frozen_q;
    logic               immune_q;
    logic               freeze_pulse_q;
    logic [ID_W-1:0]    hit_id_q;
    logic [TL_W-1:0]    ticks_left_q;

    logic [X_W:0]       w_fx;
    logic [Y_W:0]       w_fy;
    logic [N_ENEMY-1:0] w_hit;
    logic [ID_W-1:0]    w_hit_id;

    assign w_fx = {1'b0, x_blue} + C_FOOT_DX;
    assign w_fy = {1'b0, y_blue} + C_FOOT_DY;

    // Tolerance is added to both sides instead of subtracted, so an enemy
    // near y=0 cannot underflow into a false hit.
    generate
        for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_hit
            logic [X_W:0] w_xe;
            logic [Y_W:0] w_ye;
            assign w_xe = {1'b0, x_enemy[gi*X_W +: X_W]};
            assign w_ye = {1'b0, y_enemy[gi*Y_W +: Y_W]};
            assign w_hit[gi] = enemy_vld[gi]
                             & (w_fx > w_xe)
                             & (w_fx < (w_xe + C_ENEMY_W))
                             & (w_fy < (w_ye + C_TOL_Y))
                             & ((w_fy + C_TOL_Y) > w_ye);
        end
    endgenerate

    // Priority encoder: lowest set channel of the registered hit vector wins.
    always_comb begin
        w_hit_id = '0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (hit_vec_q[i]) begin
                w_hit_id = ID_W'(i);
            end
        end
    end

    // Stage 1: register the per-channel hit vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_vec_q <= '0;
        end else begin
            hit_vec_q <= w_hit;
        end
    end

    // Stage 2: freeze/immunity state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            frozen_q       <= 1'b0;
            immune_q       <= 1'b0;
            freeze_pulse_q <= 1'b0;
            hit_id_q       <= '0;
            ticks_left_q   <= '0;
        end else begin
            freeze_pulse_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|hit_vec_q) begin
                        state_q        <= S_FROZEN;
                        frozen_q       <= 1'b1;
                        ticks_left_q   <= C_FREEZE;
                        hit_id_q       <= w_hit_id;
                        freeze_pulse_q <= 1'b1;
                    end
                end
                S_FROZEN: begin
`ifdef FREEZE_RETRIGGER_EN
                    // A fresh stomp restarts the freeze; it beats a tick.
                    if (|hit_vec_q) begin
                        ticks_left_q   <= C_FREEZE;
                        hit_id_q       <= w_hit_id;
                        freeze_pulse_q <= 1'b1;
                    end else
`endif
                    if (tick) begin
                        if (ticks_left_q == C_ONE) begin
                            frozen_q <= 1'b0;
                            if (IMMUNE_TICKS == 0) begin
                                state_q      <= S_IDLE;
                                ticks_left_q <= '0;
                            end else begin
                                state_q      <= S_IMMUNE;
                                immune_q     <= 1'b1;
                                ticks_left_q <= C_IMMUNE;
                            end
                        end else begin
                            ticks_left_q <= ticks_left_q - C_ONE;
                        end
                    end
                end
                S_IMMUNE: begin
                    if (tick) begin
                        if (ticks_left_q == C_ONE) begin
                            state_q      <= S_IDLE;
                            immune_q     <= 1'b0;
                            ticks_left_q <= '0;
                        end else begin
                            ticks_left_q <= ticks_left_q - C_ONE;
                        end
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    frozen_q     <= 1'b0;
                    immune_q     <= 1'b0;
                    ticks_left_q <= '0;
                end
            endcase
        end
    end

    assign frozen       = frozen_q;
    assign immune       = immune_q;
    assign freeze_pulse = freeze_pulse_q;
    assign hit_id       = hit_id_q;
    assign ticks_left   = ticks_left_q;

endmodule
`default_nettype wire
